// File: rtl/wshb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wshb_arb_pkg
// Shared types and widths for the two-master Wishbone arbiter.
//   arb_state_t : arbiter owner state (IDLE / OWN0 / OWN1)
//   CTI_W, BTE_W, SEL_W, DAT_W : Wishbone field widths
//   state_grant : maps a state to its one-hot grant vector
// ---------------------------------------------------------------------------
package wshb_arb_pkg;

  localparam int CTI_W = 3;
  localparam int BTE_W = 2;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;

  // The encoding is chosen so that the state bits are already the one-hot
  // grant vector, so decoding grant costs nothing.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  function automatic logic [1:0] state_grant(arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wshb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wshb_arbiter_if
// One Wishbone B4 classic/registered-feedback link.
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives
//                    ack/dat_sm
//   slave modport  : the mirror image
// Parameter AW sets the address width.
// ---------------------------------------------------------------------------
interface wshb_arbiter_if #(
  parameter int AW = 32
);
  import wshb_arb_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [AW-1:0]    adr;
  logic [DAT_W-1:0] dat_ms;
  logic [SEL_W-1:0] sel;
  logic [CTI_W-1:0] cti;
  logic [BTE_W-1:0] bte;
  logic             ack;
  logic [DAT_W-1:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, dat_sm
  );

endinterface

// File: rtl/wshb_arbiter.sv
// ---------------------------------------------------------------------------
// wshb_arbiter
// Two-master round-robin Wishbone arbiter in front of one shared slave
// (master 0 = VGA frame reader, master 1 = frame writer, slave = SDRAM ctrl).
// A master keeps the bus while it holds cyc; if the other master is waiting,
// the owner is preempted on the ack that completes its QUANTUM-th access.
//
// Ports
//   clk   : Wishbone bus clock
//   rst_n : synchronous active-low reset
//   m0    : master 0 link (slave modport, arbiter acts as its slave)
//   m1    : master 1 link
//   s     : shared slave link (master modport)
//   grant : one-hot current owner, 00 = idle
// Parameters
//   QUANTUM : acks per tenure while the other master is requesting
//   AW      : address width
// ---------------------------------------------------------------------------
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int QUANTUM = 64,
  parameter int AW      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wshb_arbiter_if.slave        m0,
  wshb_arbiter_if.slave        m1,
  wshb_arbiter_if.master       s,
  output logic [1:0]           grant
);

  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(QUANTUM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW-1:0]    ADR_ZERO = '0;

  arb_state_t       state_q;
  logic [CNT_W-1:0] ack_cnt_q;
  logic             last_q;

  // Owner FSM. Besides the state it tracks the number of acks in the
  // current tenure and which master was granted last. Release (owner drops
  // cyc) is tested before preemption, so a simultaneous release+ack simply
  // follows the release rule. Preemption uses ">=" rather than "==" so that
  // an owner whose counter already saturated while alone still yields on its
  // next ack once the other master starts requesting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      last_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last_q)) begin
            state_q   <= OWN0;
            last_q    <= 1'b0;
            ack_cnt_q <= '0;
          end else if (m1.cyc) begin
            state_q   <= OWN1;
            last_q    <= 1'b1;
            ack_cnt_q <= '0;
          end
        end
        OWN0: begin
          if (!m0.cyc) begin
            ack_cnt_q <= '0;
            if (m1.cyc) begin
              state_q <= OWN1;
              last_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (s.ack && m1.cyc && (ack_cnt_q >= CNT_PRE)) begin
            state_q   <= OWN1;
            last_q    <= 1'b1;
            ack_cnt_q <= '0;
          end else if (s.ack && (ack_cnt_q != CNT_MAX)) begin
            ack_cnt_q <= ack_cnt_q + CNT_ONE;
          end
        end
        OWN1: begin
          if (!m1.cyc) begin
            ack_cnt_q <= '0;
            if (m0.cyc) begin
              state_q <= OWN0;
              last_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (s.ack && m0.cyc && (ack_cnt_q >= CNT_PRE)) begin
            state_q   <= OWN0;
            last_q    <= 1'b0;
            ack_cnt_q <= '0;
          end else if (s.ack && (ack_cnt_q != CNT_MAX)) begin
            ack_cnt_q <= ack_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          ack_cnt_q <= '0;
        end
      endcase
    end
  end

  assign grant = state_grant(state_q);

  // Bus mux. Only the registered state selects, so a master's cyc never
  // reaches the slave in the same cycle it rises. Read data is broadcast;
  // the ack tells each master whether the data is meant for it.
  always_comb begin
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.adr     = ADR_ZERO;
    s.dat_ms  = '0;
    s.sel     = '0;
    s.cti     = '0;
    s.bte     = '0;
    m0.ack    = 1'b0;
    m1.ack    = 1'b0;
    m0.dat_sm = s.dat_sm;
    m1.dat_sm = s.dat_sm;
    case (state_q)
      OWN0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_ms = m0.dat_ms;
        s.sel    = m0.sel;
        s.cti    = m0.cti;
        s.bte    = m0.bte;
        m0.ack   = s.ack;
      end
      OWN1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_ms = m1.dat_ms;
        s.sel    = m1.sel;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
        m1.ack   = s.ack;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wshb_arbiter
// Bench for wshb_arbiter with QUANTUM=4: directed scenarios followed by
// random traffic from both masters against a random-latency slave. A
// behavioural owner model tracks who should hold the bus; a compare process
// checks every output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  localparam int AW          = 32;
  localparam int QUANTUM     = 4;
  localparam int RAND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wshb_arbiter_if #(.AW(AW)) m0If ();
  wshb_arbiter_if #(.AW(AW)) m1If ();
  wshb_arbiter_if #(.AW(AW)) sIf ();
  logic [1:0] grant;

  logic          cyc[2];
  logic          stb[2];
  logic          we[2];
  logic [AW-1:0] adr[2];
  logic [31:0]   datMs[2];
  logic [3:0]    sel[2];
  logic [2:0]    cti[2];
  logic [1:0]    bte[2];
  logic          sAck;
  logic [31:0]   sDat;

  assign m0If.cyc = cyc[0];   assign m1If.cyc = cyc[1];
  assign m0If.stb = stb[0];   assign m1If.stb = stb[1];
  assign m0If.we  = we[0];    assign m1If.we  = we[1];
  assign m0If.adr = adr[0];   assign m1If.adr = adr[1];
  assign m0If.dat_ms = datMs[0]; assign m1If.dat_ms = datMs[1];
  assign m0If.sel = sel[0];   assign m1If.sel = sel[1];
  assign m0If.cti = cti[0];   assign m1If.cti = cti[1];
  assign m0If.bte = bte[0];   assign m1If.bte = bte[1];
  assign sIf.ack    = sAck;
  assign sIf.dat_sm = sDat;

  wshb_arbiter #(.QUANTUM(QUANTUM), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0If),
    .m1    (m1If),
    .s     (sIf),
    .grant (grant)
  );

  // Behavioural model: owner -1 = nobody, else master index. tenure counts
  // acks in the current tenure without limit; waitAcks counts acks the other
  // master received while this one was requesting and not served.
  int owner = -1;
  int lastServed = 1;
  int tenure = 0;
  bit acked[2];
  int waitAcks[2];
  bit checkEn = 1'b0;
  int slaveMode = 0;

  always @(posedge clk) begin : modelBlk
    int nxt;
    int other;
    for (int x = 0; x < 2; x++) begin
      acked[x] = rst_n && (owner == x) && sAck;
      if (!rst_n || !cyc[x] || owner == x) waitAcks[x] = 0;
      else if (owner == 1 - x && sAck) waitAcks[x]++;
    end
    if (!rst_n) begin
      owner = -1;
      lastServed = 1;
      tenure = 0;
    end else if (owner < 0) begin
      if (cyc[0] && cyc[1]) nxt = 1 - lastServed;
      else if (cyc[0])      nxt = 0;
      else if (cyc[1])      nxt = 1;
      else                  nxt = -1;
      if (nxt >= 0) begin
        owner = nxt;
        lastServed = nxt;
        tenure = 0;
      end
    end else begin
      other = 1 - owner;
      if (!cyc[owner]) begin
        owner = cyc[other] ? other : -1;
        if (owner >= 0) lastServed = owner;
        tenure = 0;
      end else if (sAck) begin
        tenure++;
        if (cyc[other] && tenure >= QUANTUM) begin
          owner = other;
          lastServed = other;
          tenure = 0;
        end
      end
    end
  end

  // Slave model: 0 = acks set by the stimulus, 1 = acks every strobe,
  // 2 = acks a strobe with random latency, 3 = ack stuck high.
  always @(posedge clk) begin
    #2;
    case (slaveMode)
      1: sAck = sIf.cyc & sIf.stb;
      2: sAck = sIf.cyc & sIf.stb & ($urandom % 3 != 0);
      3: sAck = 1'b1;
      default: ;
    endcase
    sDat = $urandom;
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin : compareBlk
    logic [1:0]   eGrant;
    logic [127:0] eBus;
    logic [127:0] aBus;
    if (checkEn) begin
      eGrant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      eBus = '0;
      if (owner >= 0)
        eBus = {52'd0, cyc[owner], stb[owner], we[owner], adr[owner],
                datMs[owner], sel[owner], cti[owner], bte[owner]};
      aBus = {52'd0, sIf.cyc, sIf.stb, sIf.we, sIf.adr, sIf.dat_ms,
              sIf.sel, sIf.cti, sIf.bte};
      checkOutput("grant", grant, eGrant);
      checkOutput("slaveBus", aBus, eBus);
      checkOutput("m0_ack", m0If.ack, (owner == 0) && sAck);
      checkOutput("m1_ack", m1If.ack, (owner == 1) && sAck);
      checkOutput("m0_dat_sm", m0If.dat_sm, sDat);
      checkOutput("m1_dat_sm", m1If.dat_sm, sDat);
      checkOutput("ackOneHot", m0If.ack & m1If.ack, 1'b0);
      checkOutput("starve0", waitAcks[0] <= QUANTUM, 1'b1);
      checkOutput("starve1", waitAcks[1] <= QUANTUM, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int x);
    adr[x]   = {$urandom} & 32'hFFFF_FFFC;
    we[x]    = $urandom % 2;
    datMs[x] = $urandom;
    sel[x]   = $urandom;
    cti[x]   = $urandom;
    bte[x]   = $urandom;
  endtask

  task automatic idleMasters();
    tick();
    for (int x = 0; x < 2; x++) begin
      cyc[x] = 0; stb[x] = 0; we[x] = 0; adr[x] = '0;
      datMs[x] = '0; sel[x] = '0; cti[x] = '0; bte[x] = '0;
    end
    slaveMode = 0;
    sAck = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    checkEn = 1'b1;
    #1;
    rst_n = 1'b1;
  endtask

  int rem[2];
  int n0, n1;
  bit seen, ok;

  initial begin
    for (int x = 0; x < 2; x++) begin
      cyc[x] = 0; stb[x] = 0; we[x] = 0; adr[x] = '0;
      datMs[x] = '0; sel[x] = '0; cti[x] = '0; bte[x] = '0;
    end
    sAck = 0;
    sDat = '0;

    // Single master, slave acks every strobe.
    doReset();
    slaveMode = 1;
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h0000_0100;
    @(negedge clk);
    checkOutput("lit idleGrant", grant, 2'b00);
    checkOutput("lit noCombCyc", sIf.cyc, 1'b0);
    @(negedge clk);
    checkOutput("lit grantM0", grant, 2'b01);
    checkOutput("lit sAdr", sIf.adr, 32'h0000_0100);
    checkOutput("lit m1AckIdle", m1If.ack, 1'b0);
    tick();
    adr[0] = 32'h0000_0104;
    @(negedge clk);
    checkOutput("lit sAdrNext", sIf.adr, 32'h0000_0104);
    checkOutput("lit m0AckFwd", m0If.ack, 1'b1);

    // Simultaneous request after reset, then hand-over without idle gap.
    idleMasters();
    doReset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit bothFirstM0", grant, 2'b01);
    tick();
    cyc[0] = 0; stb[0] = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit directHandover", grant, 2'b10);

    // Quantum preemption both ways.
    idleMasters();
    doReset();
    slaveMode = 1;
    cyc[0] = 1; stb[0] = 1;
    @(posedge clk);
    #1;
    cyc[1] = 1; stb[1] = 1;
    n0 = 0; seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant == 2'b10) begin seen = 1; break; end
      n0 += int'(m0If.ack);
    end
    checkOutput("lit preemptReached", seen, 1'b1);
    checkOutput("lit m0QuantumAcks", n0, 4);
    checkOutput("lit m0Stalled", m0If.ack, 1'b0);
    n1 = 0; seen = 0;
    for (int i = 0; i < 50; i++) begin
      n1 += int'(m1If.ack);
      @(negedge clk);
      if (grant == 2'b01) begin seen = 1; break; end
    end
    checkOutput("lit returnReached", seen, 1'b1);
    checkOutput("lit m1QuantumAcks", n1, 4);

    // Lone owner keeps the bus; counter saturates.
    idleMasters();
    doReset();
    slaveMode = 1;
    cyc[0] = 1; stb[0] = 1;
    @(posedge clk);
    ok = 1; n0 = 0;
    for (int i = 0; i < 205; i++) begin
      @(negedge clk);
      if (grant != 2'b01) ok = 0;
      n0 += int'(m0If.ack);
    end
    checkOutput("lit loneHeld", ok, 1'b1);
    checkOutput("lit loneAcks", n0 >= 200, 1'b1);
    checkOutput("lit ackCntSat", dut.ack_cnt_q, QUANTUM);
    tick();
    cyc[1] = 1; stb[1] = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit lateCompetitor", grant, 2'b10);

    // Reset while master 1 is being acked.
    idleMasters();
    doReset();
    slaveMode = 1;
    cyc[1] = 1; stb[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    slaveMode = 3;
    sAck = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit rstGrant", grant, 2'b00);
    checkOutput("lit rstSCyc", sIf.cyc, 1'b0);
    checkOutput("lit rstM1Ack", m1If.ack, 1'b0);
    tick();
    rst_n = 1;
    slaveMode = 0;
    sAck = 0;
    cyc[0] = 1; stb[0] = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit postRstM0", grant, 2'b01);

    // Random traffic on both masters, random-latency slave.
    idleMasters();
    doReset();
    slaveMode = 2;
    rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        if (!cyc[x]) begin
          if ($urandom % 4 == 0) begin
            cyc[x] = 1; stb[x] = 1;
            rem[x] = $urandom_range(1, 12);
            applyStimulus(x);
          end
        end else if (acked[x]) begin
          rem[x]--;
          if (rem[x] == 0) begin
            cyc[x] = 0; stb[x] = 0;
          end else begin
            applyStimulus(x);
            stb[x] = ($urandom % 4 != 0);
          end
        end else if (!stb[x]) begin
          stb[x] = 1;
        end
      end
    end

    idleMasters();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 The block SHALL have parameter QUANTUM, default 64: maximum acks granted to one master per tenure while the other master is requesting.
REQ-002 The block SHALL have parameter AW, default 32: Wishbone address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the Wishbone bus clock (100 MHz).
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have ports m0_cyc, m0_stb, m0_we, input, 1 bit each: master 0 (VGA frame reader) cycle, strobe and write enable.
REQ-006 The block SHALL have ports m0_adr (AW), m0_dat_ms (32), m0_sel (4), m0_cti (3) and m0_bte (2), all inputs: master 0 address, write data, byte selects and burst tags.
REQ-007 The block SHALL have outputs m0_ack (1) and m0_dat_sm (32): master 0 acknowledge and read data.
REQ-008 The block SHALL have m1_* ports, identical to the m0_* ports: master 1 (frame writer).
REQ-009 The block SHALL have outputs s_cyc, s_stb, s_we (1 bit each), s_adr (AW), s_dat_ms (32), s_sel (4), s_cti (3) and s_bte (2): the shared slave (SDRAM controller) side.
REQ-010 The block SHALL have inputs s_ack (1) and s_dat_sm (32): slave acknowledge and read data.
REQ-011 The block SHALL have output grant, 2 bits: one-hot current owner; 00 means idle.

Function
REQ-012 The FSM SHALL have states IDLE, OWN0 and OWN1, and grant SHALL be decoded directly from the state.
REQ-013 In IDLE, with only mX_cyc=1, the FSM SHALL move to OWNX on the next edge.
REQ-014 In IDLE with both cyc=1, the FSM SHALL grant the master not served last; after reset, last-served is master 1, so master 0 wins first.
REQ-015 Slave-side outputs SHALL be a combinational mux of the owner's signals selected by the registered state; in IDLE, s_cyc=s_stb=s_we=0 and the other slave-side outputs are 0.
REQ-016 The owner's mX_ack SHALL equal s_ack; the non-owner's mX_ack SHALL be 0; both mX_dat_sm SHALL carry s_dat_sm unconditionally.
REQ-017 The non-owner's request SHALL never reach the slave; that master simply waits (stb held, no ack), which is legal Wishbone stalling.
REQ-018 Latency: the slave SHALL see the owner's stb exactly 1 cycle after cyc is asserted from IDLE; there SHALL be no combinational path from mX_cyc to s_cyc.
REQ-019 In OWNX, the counter ack_cnt SHALL increment on each s_ack; it SHALL be width $clog2(QUANTUM+1) and saturate at QUANTUM.
REQ-020 Release: in OWNX with mX_cyc=0, the FSM SHALL go to OWN(other) if the other master's cyc=1, otherwise to IDLE.
REQ-021 Preemption: in OWNX, on an edge with s_ack=1, ack_cnt==QUANTUM-1 and the other master's cyc=1, the FSM SHALL go to OWN(other).
REQ-022 Preemption SHALL occur only on an ack edge, so no transaction is split.
REQ-023 Without a competing request, the owner SHALL keep the bus indefinitely; ack_cnt SHALL saturate and not wrap.
REQ-024 ack_cnt SHALL clear on every state change.
REQ-025 last-served SHALL update on every entry into OWNX.
REQ-026 Simultaneous release and ack: the release rule SHALL take precedence; the result is identical in either case when the other master is requesting.
REQ-027 A preempted master that still holds cyc SHALL be re-granted, with the same round-robin rule, once the other master releases or is itself preempted.
REQ-028 The switch OWNX to OWN(other) SHALL be direct, with no IDLE bubble.

Reset
REQ-029 On clk edge with rst_n=0: state=IDLE, ack_cnt=0, last-served=1; consequently grant=00, s_cyc=s_stb=0, m0_ack=m1_ack=0 from the following cycle.
REQ-030 Reset mid-burst SHALL abandon the transaction; no ack SHALL be forwarded while rst_n=0 is registered.
REQ-031 All flops SHALL be reset; there SHALL be no initial-value-only registers.

Structure
REQ-032 Package wshb_arb_pkg SHALL hold typedef enum arb_state_t {IDLE, OWN0, OWN1} and the localparams CTI_W=3, BTE_W=2, SEL_W=4, DAT_W=32.
REQ-033 wshb_arbiter SHALL be a single module with no sub-module; the slave mux and the FSM SHALL be two processes within it.

Verification
REQ-034 Only m0_cyc=1, slave acks every cycle -> grant=01 one cycle later, s_adr follows m0_adr, m1_ack stays 0.
REQ-035 m0_cyc and m1_cyc rise in the same cycle after reset -> OWN0 first; m0 drops cyc -> OWN1 on the next edge, with no IDLE gap.
REQ-036 QUANTUM=4, m0 streams continuously, m1 requests -> after m0's 4th ack, grant=10; m0 stalls with stb=1 and ack=0; m1 gets 4 acks; grant returns to 01.
REQ-037 m0 alone, 200 acks -> grant stays 01 throughout and ack_cnt saturates at QUANTUM.
REQ-038 rst_n=0 during OWN1 with s_ack=1 -> next cycle grant=00, s_cyc=0, m1_ack=0; after release, a simultaneous request grants m0.
REQ-039 Random cyc/stb on both masters with a random-latency slave model -> at most one master acked per cycle, every slave ack forwarded to exactly the owner, and no request starved beyond QUANTUM acks of the other.
